// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2 stride-2 signed max pooling of a word-packed int8 feature map, BRAM to BRAM.
// Six cycles per output word. Define MAXPOOL_RELU_EN to clamp negative pooled bytes to zero.
module maxpool2x2 #(
   parameter int IMG_W    = 24,
   parameter int IMG_H    = 24,
   parameter int CH       = 1,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        finish,
   output logic        S_R_req,
   output logic [31:0] S_addr,
   input  logic [31:0] S_R_data,
   output logic        D_R_req,
   output logic [31:0] D_addr,
   output logic [3:0]  D_W_req,
   output logic [31:0] D_W_data
);

   localparam int WORDS_PER_ROW = IMG_W / 4;
   localparam int OUT_PER_ROW   = IMG_W / 8;
   localparam int OUT_ROWS      = IMG_H / 2;
   localparam int PLANE_WORDS   = IMG_H * WORDS_PER_ROW;
   localparam int OUT_PLANE     = OUT_ROWS * OUT_PER_ROW;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      R0   = 3'd1,
      R1   = 3'd2,
      R2   = 3'd3,
      R3   = 3'd4,
      C    = 3'd5,
      W    = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] k_cnt, r_cnt, c_cnt;
   logic [31:0] rd_buf [4];
   logic [31:0] pooled;
   logic        last_k, last_r, last_c, last_word;
   logic        row_sel, grp_sel;

   assign last_k    = (k_cnt == 32'(OUT_PER_ROW - 1));
   assign last_r    = (r_cnt == 32'(OUT_ROWS - 1));
   assign last_c    = (c_cnt == 32'(CH - 1));
   assign last_word = last_k && last_r && last_c;

   function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         finish <= 1'b0;
         k_cnt  <= '0;
         r_cnt  <= '0;
         c_cnt  <= '0;
         for (int i = 0; i < 4; i++) rd_buf[i] <= '0;
      end else begin
         state  <= state_nxt;
         finish <= (state == DONE);
         // Each capture takes the data for the read issued one state earlier.
         case (state)
            R1: rd_buf[0] <= S_R_data;
            R2: rd_buf[1] <= S_R_data;
            R3: rd_buf[2] <= S_R_data;
            C:  rd_buf[3] <= S_R_data;
            default: ;
         endcase
         if (state == W) begin
            if (last_k) begin
               k_cnt <= '0;
               if (last_r) begin
                  r_cnt <= '0;
                  c_cnt <= last_c ? '0 : c_cnt + 32'd1;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end else begin
               k_cnt <= k_cnt + 32'd1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = R0;
         R0:      state_nxt = R1;
         R1:      state_nxt = R2;
         R2:      state_nxt = R3;
         R3:      state_nxt = C;
         C:       state_nxt = W;
         W:       state_nxt = last_word ? DONE : R0;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pixel pair (2j, 2j+1) of an 8-pixel row sits in word j/2 at bytes 2*(j%2) and 2*(j%2)+1.
   always_comb begin
      logic [31:0] top, bot;
      logic [7:0]  m;
      int          b;
      pooled = '0;
      for (int j = 0; j < 4; j++) begin
         top = (j < 2) ? rd_buf[0] : rd_buf[1];
         bot = (j < 2) ? rd_buf[2] : rd_buf[3];
         b   = (j % 2) * 2;
         m   = smax(smax(top[31-8*b -: 8], top[23-8*b -: 8]),
                    smax(bot[31-8*b -: 8], bot[23-8*b -: 8]));
`ifdef MAXPOOL_RELU_EN
         if (m[7]) m = 8'h00;
`endif
         pooled[31-8*j -: 8] = m;
      end
   end

   always_comb begin
      S_R_req  = 1'b0;
      S_addr   = '0;
      D_R_req  = 1'b0;
      D_addr   = '0;
      D_W_req  = 4'b0000;
      D_W_data = '0;
      row_sel  = (state == R2) || (state == R3);
      grp_sel  = (state == R1) || (state == R3);
      case (state)
         R0, R1, R2, R3: begin
            S_R_req = 1'b1;
            S_addr  = 32'(SRC_BASE) + c_cnt * 32'(PLANE_WORDS)
                    + ((r_cnt << 1) + {31'b0, row_sel}) * 32'(WORDS_PER_ROW)
                    + (k_cnt << 1) + {31'b0, grp_sel};
         end
         W: begin
            // A reset landing on the write cycle must not let that word reach the BRAM.
            D_W_req  = rst ? 4'b0000 : 4'b1111;
            D_addr   = 32'(DST_BASE) + c_cnt * 32'(OUT_PLANE)
                     + r_cnt * 32'(OUT_PER_ROW) + k_cnt;
            D_W_data = pooled;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_maxpool2x2.sv
// Bench for maxpool2x2: two instances (default and CH=2/DST_BASE=100) against a pixel-level max-pool model.
module tb_maxpool2x2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic        fin0, sreq0, dreq0, fin1, sreq1, dreq1;
   logic [31:0] saddr0, sdata0 = '0, daddr0, wdata0;
   logic [31:0] saddr1, sdata1 = '0, daddr1, wdata1;
   logic [3:0]  wreq0, wreq1;

   maxpool2x2 u0 (
      .clk(clk), .rst(rst), .start(start0), .finish(fin0),
      .S_R_req(sreq0), .S_addr(saddr0), .S_R_data(sdata0),
      .D_R_req(dreq0), .D_addr(daddr0), .D_W_req(wreq0), .D_W_data(wdata0)
   );

   maxpool2x2 #(.CH(2), .DST_BASE(100)) u1 (
      .clk(clk), .rst(rst), .start(start1), .finish(fin1),
      .S_R_req(sreq1), .S_addr(saddr1), .S_R_data(sdata1),
      .D_R_req(dreq1), .D_addr(daddr1), .D_W_req(wreq1), .D_W_data(wdata1)
   );

   logic [7:0]  px [2][24][24];
   logic [31:0] dmem0 [256];
   logic [31:0] dmem1 [256];
   int          wgen0 [256];
   int          wgen1 [256];
   int          run_id = 1;
   int          cyc = 0;
   int          fin_cnt0 = 0, fin_cyc0 = 0, fin_cnt1 = 0, fin_cyc1 = 0;
   logic [31:0] last1 = '0;
   int          total = 0, bad = 0;

   function automatic logic [31:0] src_word(input int a);
      int c, rem, y, xw;
      if (a < 0 || a >= 288) return 32'h0;
      c   = a / 144;
      rem = a % 144;
      y   = rem / 6;
      xw  = rem % 6;
      return {px[c][y][4*xw], px[c][y][4*xw+1], px[c][y][4*xw+2], px[c][y][4*xw+3]};
   endfunction

   // Reference: output pixel (oy,ox) is the signed max of the 2x2 input block at (2oy,2ox).
   function automatic logic [31:0] exp_word(input int c, input int oy, input int ok);
      logic [31:0] w;
      int ox, best, v;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         ox = 4 * ok + j;
         best = -129;
         for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
               v = int'($signed(px[c][2*oy+dy][2*ox+dx]));
               if (v > best) best = v;
            end
`ifdef MAXPOOL_RELU_EN
         if (best < 0) best = 0;
`endif
         w[31-8*j -: 8] = 8'(best);
      end
      return w;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sreq0) sdata0 <= src_word(int'(saddr0));
      if (sreq1) sdata1 <= src_word(int'(saddr1));
      if (sreq1) last1 <= saddr1;
      if (wreq0 == 4'hF) begin
         dmem0[daddr0[7:0]] <= wdata0;
         wgen0[daddr0[7:0]] <= run_id;
      end
      if (wreq1 == 4'hF) begin
         dmem1[daddr1[7:0]] <= wdata1;
         wgen1[daddr1[7:0]] <= run_id;
      end
      if (fin0) begin
         fin_cnt0 <= fin_cnt0 + 1;
         fin_cyc0 <= cyc;
      end
      if (fin1) begin
         fin_cnt1 <= fin_cnt1 + 1;
         fin_cyc1 <= cyc;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called and returns at #1 after a rising edge; start is presented in that cycle.
   task automatic run0(input bit busy, input bit tail, input string nm);
      int t0, f0, n;
      run_id++;
      f0 = fin_cnt0;
      t0 = cyc;
      start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      if (busy) begin
         repeat (49) @(posedge clk);
         #1 start0 = 1'b1;
         @(posedge clk); #1 start0 = 1'b0;
      end
      n = 0;
      while (fin_cnt0 == f0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (tail) begin
         repeat (30) @(posedge clk);
         #1;
      end
      check_eq({nm, "_fin_cnt"}, 64'(fin_cnt0 - f0), 64'd1);
      check_eq({nm, "_latency"}, 64'(fin_cyc0 - t0), 64'd218);
      for (int w = 0; w < 36; w++)
         check_eq($sformatf("%s_w%0d", nm, w), {31'b0, wgen0[w] == run_id, dmem0[w]},
                  {31'b0, 1'b1, exp_word(0, w / 3, w % 3)});
   endtask

   task automatic fill_random();
      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 24; y++)
            for (int x = 0; x < 24; x++)
               px[c][y][x] = 8'($urandom);
   endtask

   initial begin
      int n, f0, t0;
      logic [7:0] exp_neg;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_finish", fin0, 0);
      check_eq("rst_s_req", sreq0, 0);
      check_eq("rst_s_addr", saddr0, 0);
      check_eq("rst_d_rreq", dreq0, 0);
      check_eq("rst_d_addr", daddr0, 0);
      check_eq("rst_d_wreq", wreq0, 0);
      check_eq("rst_d_wdata", wdata0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int c = 0; c < 2; c++)
         for (int y = 0; y < 24; y++)
            for (int x = 0; x < 24; x++)
               px[c][y][x] = 8'((y * 24 + x) & 8'h7f);
      run0(1'b0, 1'b1, "ramp");
      check_eq("ramp_word0", dmem0[0], 32'h191b1d1f);

      fill_random();
      px[0][0][0] = 8'h80; px[0][0][1] = 8'hff; px[0][1][0] = 8'hfe; px[0][1][1] = 8'h81;
      px[0][0][2] = 8'h7f; px[0][0][3] = 8'h80; px[0][1][2] = 8'h00; px[0][1][3] = 8'h01;
      run0(1'b0, 1'b1, "signed");
`ifdef MAXPOOL_RELU_EN
      exp_neg = 8'h00;
`else
      exp_neg = 8'hff;
`endif
      check_eq("signed_neg", dmem0[0][31:24], exp_neg);
      check_eq("signed_pos", dmem0[0][23:16], 8'h7f);

      fill_random();
      run0(1'b1, 1'b1, "busy");

      fill_random();
      run_id++;
      f0 = fin_cnt0;
      start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
      n = 0;
      while (!(wreq0 == 4'hF && daddr0 == 32'd10) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("rst_reach_w10", daddr0, 10);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("mid_finish", fin0, 0);
      check_eq("mid_s_req", sreq0, 0);
      check_eq("mid_s_addr", saddr0, 0);
      check_eq("mid_d_rreq", dreq0, 0);
      check_eq("mid_d_addr", daddr0, 0);
      check_eq("mid_d_wreq", wreq0, 0);
      check_eq("mid_d_wdata", wdata0, 0);
      rst = 1'b0;
      check_eq("mid_no_w10", 64'(wgen0[10] == run_id), 0);
      check_eq("mid_w9_written", 64'(wgen0[9] == run_id), 1);
      repeat (20) @(posedge clk);
      #1;
      check_eq("mid_no_finish", 64'(fin_cnt0 - f0), 0);
      run0(1'b0, 1'b1, "rerun");

      fill_random();
      run0(1'b0, 1'b0, "b2b_a");
      run0(1'b0, 1'b1, "b2b_b");

      fill_random();
      run_id++;
      f0 = fin_cnt1;
      t0 = cyc;
      start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      n = 0;
      while (fin_cnt1 == f0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (10) @(posedge clk);
      #1;
      check_eq("ch2_fin_cnt", 64'(fin_cnt1 - f0), 1);
      check_eq("ch2_latency", 64'(fin_cyc1 - t0), 434);
      check_eq("ch2_last_src", last1, 287);
      for (int w = 0; w < 72; w++)
         check_eq($sformatf("ch2_w%0d", 100 + w),
                  {31'b0, wgen1[100 + w] == run_id, dmem1[100 + w]},
                  {31'b0, 1'b1, exp_word(w / 36, (w % 36) / 3, w % 3)});
      check_eq("ch2_below", 64'(wgen1[99] == run_id), 0);
      check_eq("ch2_above", 64'(wgen1[172] == run_id), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maxpool2x2.md
# maxpool2x2

Downstream stage of the `conv` block. After `conv` signals `finish`, this block reads the ReLU feature map from its BRAM (4 signed 8-bit pixels per 32-bit word) and performs 2x2, stride-2 max pooling per channel. It writes the pooled map, packed the same way, into a destination BRAM. It is started with a one-cycle `start` pulse and reports completion with a one-cycle `finish` pulse.

## Interface
- `IMG_W`, default 24: input width in pixels; must be a multiple of 8.
- `IMG_H`, default 24: input height in pixels; must be even.
- `CH`, default 1: number of channels, stored plane after plane.
- `SRC_BASE`, default 0: word address of the first input word.
- `DST_BASE`, default 0: word address of the first output word.
- `clk` in 1: clock. Everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse. Accepted only in IDLE.
- `finish` out 1: one-cycle pulse when the last word has been written.
- `S_R_req` out 1: source read request.
- `S_addr` out 32: source word address.
- `S_R_data` in 32: source read data. Valid on the cycle after `S_R_req`.
- `D_R_req` out 1: destination read request. Held at 0.
- `D_addr` out 32: destination word address.
- `D_W_req` out 4: destination byte-write enables. Values are 4'b1111 or 0.
- `D_W_data` out 32: destination write data.

## Operation
- Packing: pixel `4n+j` lives in word `n`, bits `[31-8j -: 8]` (byte 0 is the MSB). Input and output use the same packing.
- Work unit: one output word, which is 4 pooled pixels. Each output word reads 4 input words: row 2r at column groups 2k and 2k+1, then row 2r+1 at column groups 2k and 2k+1.
- Input word address: `SRC_BASE + c*IMG_H*IMG_W/4 + row*IMG_W/4 + grp`.
- Output word address: `DST_BASE + c*(IMG_H/2)*(IMG_W/8) + r*(IMG_W/8) + k`.
- Iteration order is k fastest, then r, then c.
- Output pixel j of word k is the signed max of 4 inputs: the pixel pair at columns 2j and 2j+1 of both rows, taken from the 8 pixels in the two words of that row.
- Comparison is two's-complement int8. The result is exact; there is no rounding or saturation.
- FSM states:
  - IDLE: on `start`, go to R0.
  - R0, R1, R2, R3: issue one read per cycle (`S_R_req`=1).
  - C: capture the last read data.
  - W: write the output word.
  - DONE: pulse `finish`.
- Transitions:
  - IDLE→R0 on `start`.
  - R0→R1→R2→R3→C→W.
  - W→R0 if words remain, W→DONE after the last word.
  - DONE→IDLE unconditionally.
- Read data is captured into a 4-word buffer in R1, R2, R3 and C.
- A running max over pixel pairs is allowed. The only requirement is that the value written in W is correct.
- `start` is ignored in every state other than IDLE.
- `S_*` and `D_*` are idle (0) in every state except the ones that drive them.

## Timing
- Reset values: `finish`=0, `S_R_req`=0, `S_addr`=0, `D_R_req`=0, `D_addr`=0, `D_W_req`=0, `D_W_data`=0. FSM returns to IDLE and all counters clear.
- Reset mid-operation: takes effect on the next edge. No further write is issued and `finish` is not asserted.
- Read timing: the address is presented with `S_R_req` in cycle t, and the data is sampled in cycle t+1.
- Write timing: `D_W_req`=4'b1111, `D_addr` and `D_W_data` are all valid in the same cycle (W) for exactly one cycle.
- Throughput: 6 cycles per output word.
- Total latency: 1 + 6·N + 1 cycles, from the `start` edge to `finish` high, where N = CH·(IMG_H/2)·(IMG_W/8). With the defaults, N=36 and `finish` comes 218 cycles after `start`.
- Back-to-back runs: `start` in the cycle right after `finish` is accepted, because the FSM is already in IDLE.
- Simultaneous `rst` and `start`: `rst` wins.

## Configuration
- `MAXPOOL_RELU_EN` defined: every output byte whose max is negative (bit 7 = 1) is written as 8'h00. This fused ReLU allows a raw, non-rectified feature map as input.
- `MAXPOOL_RELU_EN` not defined: the signed max is written unchanged, so negative values pass through.

## Test plan
- Ramp, defaults: input byte at (row y, col x) = `(y*24+x)&8'h7f`. Word 0 must equal `{8'h19,8'h1b,8'h1d,8'h1f}`. All 36 words must match the software model, and `finish` must be high exactly 218 cycles after `start`.
- Signed compare: a block of inputs {8'h80, 8'hff, 8'hfe, 8'h81}.
  - Without the macro, the output byte is 8'hff.
  - With `MAXPOOL_RELU_EN`, the output byte is 8'h00.
  - The {8'h7f, 8'h80, 8'h00, 8'h01} case must give 8'h7f in both builds.
- `start` while busy: pulse `start` again at cycle 50. There must be no restart, output identical to the single-start run, and only one `finish`.
- Reset mid-run: assert `rst` during the W state of word 10. Next cycle every output is 0 and the FSM is in IDLE. No write occurs to word 10, and a fresh `start` completes correctly.
- Multi-channel, CH=2, `DST_BASE`=100: channel 1 results land at words 136..171. The last source address is `SRC_BASE`+287, and `finish` comes at cycle 434.
- Back-to-back: `start` in the cycle after `finish` is accepted, and the second run produces an identical result.
